// File: rtl/alu_scan_ctrl.sv
// Scan test sequencer for the ALU scan-chain register: load pattern, capture, unload, compare.
// Optional FLUSH pass (chain integrity check) enabled by defining ALU_SCAN_CTRL_FLUSH_EN.
module alu_scan_ctrl #(
    parameter int CHAIN_LEN = 4,
    parameter int CNT_W     = 3,   // 2**CNT_W must exceed CHAIN_LEN
    parameter int ERR_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pat_in,
    input  logic [CHAIN_LEN-1:0] exp_in,
    input  logic [1:0]           op_in,
    input  logic [3:0]           a_in,
    input  logic [3:0]           b_in,
    input  logic                 chain_so,
    output logic                 scan_en,
    output logic                 scan_in,
    output logic [1:0]           op_code,
    output logic [3:0]           A,
    output logic [3:0]           B,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
`ifdef ALU_SCAN_CTRL_FLUSH_EN
        S_FLUSH,
`endif
        S_CAPTURE,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] pat_q, pat_d;
    logic [CHAIN_LEN-1:0] exp_q, exp_d;
    logic [CHAIN_LEN-1:0] cap_q, cap_d;
    logic [1:0]           op_q, op_d;
    logic [3:0]           a_q, a_d;
    logic [3:0]           b_q, b_d;
    logic                 pass_q, pass_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic                 flush_fail_q, flush_fail_d;

    logic                 cnt_last;
    logic                 result;
    logic                 shift_phase;
    logic [CHAIN_LEN-1:0] pat_shift;

    assign cnt_last = (cnt_q == CNT_W'(CHAIN_LEN - 1));
    assign result   = (cap_q == exp_q) && !flush_fail_q;

    // Pattern goes out MSB first: bit cnt of the left-shifted copy lands in the MSB.
    assign pat_shift = pat_q << cnt_q;
`ifdef ALU_SCAN_CTRL_FLUSH_EN
    assign shift_phase = (state_q == S_LOAD) || (state_q == S_FLUSH);
`else
    assign shift_phase = (state_q == S_LOAD);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            pat_q        <= '0;
            exp_q        <= '0;
            cap_q        <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            flush_fail_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pat_q        <= pat_d;
            exp_q        <= exp_d;
            cap_q        <= cap_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            flush_fail_q <= flush_fail_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pat_d        = pat_q;
        exp_d        = exp_q;
        cap_d        = cap_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        pass_d       = pass_q;
        err_d        = err_q;
        flush_fail_d = flush_fail_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pat_d        = pat_in;
                    exp_d        = exp_in;
                    op_d         = op_in;
                    a_d          = a_in;
                    b_d          = b_in;
                    cnt_d        = '0;
                    flush_fail_d = 1'b0;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                if (cnt_last) begin
                    cnt_d = '0;
`ifdef ALU_SCAN_CTRL_FLUSH_EN
                    state_d = S_FLUSH;
`else
                    state_d = S_CAPTURE;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef ALU_SCAN_CTRL_FLUSH_EN
            S_FLUSH: begin
                cap_d = {cap_q[CHAIN_LEN-2:0], chain_so};
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = S_CAPTURE;
                    if (cap_d != pat_q) begin
                        flush_fail_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_CAPTURE: begin
                cnt_d   = '0;
                state_d = S_UNLOAD;
            end
            S_UNLOAD: begin
                // chain_so is the chain MSB before this edge's shift
                cap_d = {cap_q[CHAIN_LEN-2:0], chain_so};
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                pass_d = result;
                if (!result && !(&err_q)) begin
                    err_d = err_q + ERR_W'(1);
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign scan_en = shift_phase || (state_q == S_UNLOAD);
    assign scan_in = shift_phase & pat_shift[CHAIN_LEN-1];
    assign op_code = busy ? op_q : 2'b00;
    assign A       = busy ? a_q : 4'h0;
    assign B       = busy ? b_q : 4'h0;
    // The verdict is visible during the done pulse itself and held afterwards.
    assign pass    = done ? result : pass_q;
    assign err_cnt = err_q;

endmodule

// File: tb/tb_alu_scan_ctrl.sv
// Bench for alu_scan_ctrl: two instances (default and ERR_W=2) each driving a behavioural scan-chain ALU.
module tb_alu_scan_ctrl;
    localparam int CL = 4;
`ifdef ALU_SCAN_CTRL_FLUSH_EN
    localparam int LAT = 3*CL + 2;
    localparam bit FL  = 1'b1;
`else
    localparam int LAT = 2*CL + 2;
    localparam bit FL  = 1'b0;
`endif
    localparam int CAP_N = LAT - 1 - CL;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic [3:0] pat_in = '0, exp_in = '0, a_in = '0, b_in = '0;
    logic [1:0] op_in = '0;

    logic so1, s_en1, s_in1, busy1, done1, pass1;
    logic [1:0] op1;
    logic [3:0] a1, b1;
    logic [7:0] err1;
    logic so2, s_en2, s_in2, busy2, done2, pass2;
    logic [1:0] op2;
    logic [3:0] a2, b2;
    logic [1:0] err2;

    always #5 clk = ~clk;

    alu_scan_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .pat_in(pat_in), .exp_in(exp_in),
        .op_in(op_in), .a_in(a_in), .b_in(b_in), .chain_so(so1),
        .scan_en(s_en1), .scan_in(s_in1), .op_code(op1), .A(a1), .B(b1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1)
    );

    alu_scan_ctrl #(.ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .pat_in(pat_in), .exp_in(exp_in),
        .op_in(op_in), .a_in(a_in), .b_in(b_in), .chain_so(so2),
        .scan_en(s_en2), .scan_in(s_in2), .op_code(op2), .A(a2), .B(b2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2)
    );

    // Behavioural ALU result register with scan chain (shifts toward the MSB)
    function automatic logic [3:0] alu_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    logic [3:0] alu1_q = '0, alu2_q = '0;
    bit stuck0 = 1'b0;
    always @(posedge clk) begin
        alu1_q <= s_en1 ? {alu1_q[2:0], s_in1} : alu_f(op1, a1, b1);
        alu2_q <= s_en2 ? {alu2_q[2:0], s_in2} : alu_f(op2, a2, b2);
    end
    assign so1 = stuck0 ? 1'b0 : alu1_q[3];
    assign so2 = stuck0 ? 1'b0 : alu2_q[3];

    typedef struct {
        logic [3:0] pat;
        logic [3:0] expv;
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        bit         exp_pass;
    } vec_t;

    int checks = 0;
    int failures = 0;
    bit sb_q[$];
    int err1_m = 0;
    int err2_m = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, busy1, 0);
        chk({tag, "_scan_en"}, s_en1, 0);
        chk({tag, "_scan_in"}, s_in1, 0);
        chk({tag, "_opab"}, {op1, a1, b1}, 0);
        chk({tag, "_done"}, done1, 0);
        chk({tag, "_pass"}, pass1, 0);
        chk({tag, "_err"}, err1, 0);
        chk({tag, "_err2"}, err2, 0);
    endtask

    // Called #1 after a rising edge. glitch_at/rst_at select a cycle (t1..) for the corner cases.
    task automatic run_test(input vec_t v, input int glitch_at, input int rst_at);
        int got;
        bit ep;
        got = 0;
        pat_in = v.pat; exp_in = v.expv; op_in = v.op; a_in = v.a; b_in = v.b;
        start = 1'b1;
        sb_q.push_back(v.exp_pass);
        @(posedge clk); #1;
        start = 1'b0;
        pat_in = ~v.pat; exp_in = ~v.expv; op_in = ~v.op; a_in = ~v.a; b_in = ~v.b;
        for (int n = 1; n <= LAT + 4; n++) begin
            if (n > 1) begin
                @(posedge clk); #1;
            end
            start = 1'b0;
            if (rst_at == n) begin
                rst = 1'b0;
                #1;
                check_idle_zero("abort");
                sb_q.delete();
                err1_m = 0; err2_m = 0;
                @(negedge clk);
                rst = 1'b1;
                got = 0;
                for (int k = 0; k < LAT + 2; k++) begin
                    @(posedge clk); #1;
                    if (done1 || done2) got++;
                end
                chk("abort_no_done", got, 0);
                $display("test aborted by reset at t%0d", n);
                return;
            end
            if (done1) begin
                got = n;
                break;
            end
            chk("busy", busy1, 1);
            if (n <= CL) chk("scan_in_load", s_in1, v.pat[CL-n]);
            chk("scan_en", s_en1, (n != CAP_N));
            if (n == CAP_N) chk("capture_opab", {op1, a1, b1}, {v.op, v.a, v.b});
            if (glitch_at == n) begin
                start = 1'b1;
                op_in = v.op + 2'd1; a_in = v.a + 4'd3; b_in = v.b + 4'd7;
                pat_in = v.pat ^ 4'h5; exp_in = v.expv ^ 4'hF;
            end
        end
        chk("latency", got, LAT);
        if (got != 0) begin
            chk("busy_done", busy1, 1);
            chk("done2", done2, 1);
            if (sb_q.size() == 0) begin
                chk("sb_nonempty", 0, 1);
                ep = 1'b0;
            end else begin
                ep = sb_q.pop_front();
            end
            chk("pass_at_done", pass1, ep);
            chk("pass2_at_done", pass2, ep);
            if (!ep) begin
                if (err1_m < 255) err1_m++;
                if (err2_m < 3) err2_m++;
            end
            @(posedge clk); #1;
            chk("done_pulse", done1, 0);
            chk("busy_after", busy1, 0);
            chk("opab_idle", {op1, a1, b1}, 0);
            chk("pass_hold", pass1, ep);
            chk("err_cnt", err1, err1_m);
            chk("err_cnt2", err2, err2_m);
            $display("test op=%0d A=%0d B=%0d exp=%b done@t%0d pass=%0d err=%0d err2=%0d",
                     v.op, v.a, v.b, v.expv, got, pass1, err1, err2);
        end
    endtask

    vec_t tbl[7];
    vec_t v;
    int sat_exp[5];

    initial begin
        tbl[0] = '{pat:4'b1010, expv:4'b1000, op:2'b00, a:4'd3,  b:4'd5,  exp_pass:1'b1};
        tbl[1] = '{pat:4'b0110, expv:4'b1101, op:2'b01, a:4'd2,  b:4'd5,  exp_pass:1'b1};
        tbl[2] = '{pat:4'b0001, expv:4'b0000, op:2'b11, a:4'd9,  b:4'd6,  exp_pass:1'b0};
        tbl[3] = '{pat:4'b1111, expv:4'b1000, op:2'b10, a:4'd12, b:4'd10, exp_pass:1'b1};
        tbl[4] = '{pat:4'b1001, expv:4'b0000, op:2'b00, a:4'd15, b:4'd1,  exp_pass:1'b1};
        tbl[5] = '{pat:4'b0101, expv:4'b0001, op:2'b01, a:4'd7,  b:4'd7,  exp_pass:1'b0};
        tbl[6] = '{pat:4'b1100, expv:4'b1100, op:2'b00, a:4'd6,  b:4'd6,  exp_pass:1'b1};
        sat_exp = '{1, 2, 3, 3, 3};

        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Reset during UNLOAD (t7) aborts with no done pulse
        run_test(tbl[0], 0, 7);
        @(posedge clk); #1;
        chk("post_abort_err", err1, 0);
        chk("post_abort_pass", pass1, 0);

        for (int i = 0; i < 7; i++) begin
            run_test(tbl[i], 0, 0);
        end

        // A second start while busy must be ignored
        run_test(tbl[1], 3, 0);

        // Chain output stuck low: a FLUSH build must flag it even though exp matches
        stuck0 = 1'b1;
        v = '{pat:4'b1111, expv:4'b0000, op:2'b00, a:4'd0, b:4'd0, exp_pass:!FL};
        run_test(v, 0, 0);
        stuck0 = 1'b0;

        // Saturation of the 2-bit counter from a fresh reset
        @(negedge clk);
        rst = 1'b0;
        err1_m = 0; err2_m = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            run_test(tbl[2], 0, 0);
            chk("sat_seq", err2, sat_exp[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_scan_ctrl.md
Name: alu_scan_ctrl

Overview:
Scan test sequencer for the 4-bit scan-chain ALU register. On a start pulse it shifts a pattern into the chain, applies one functional capture cycle with programmed op_code/A/B, then unloads the captured word. It compares the unloaded word against an expected value and reports pass/fail plus a saturating error count. It sits between the test access logic and the ALU's scan_en/scan_in/scan_out and operand ports.

Parameters:
CHAIN_LEN, 4, number of scan flops in the chain (= ALU result width)
CNT_W, 3, bit-counter width; must satisfy 2**CNT_W > CHAIN_LEN
ERR_W, 8, width of the saturating failed-test counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  begin a test; honoured only in IDLE
pat_in  in  CHAIN_LEN  pattern to load into the chain
exp_in  in  CHAIN_LEN  expected captured value
op_in  in  2  op_code applied during capture
a_in  in  4  operand A applied during capture
b_in  in  4  operand B applied during capture
chain_so  in  1  from ALU scan_out (chain MSB)
scan_en  out  1  to ALU scan_en
scan_in  out  1  to ALU scan_in
op_code  out  2  to ALU op_code
A  out  4  to ALU A
B  out  4  to ALU B
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at test end
pass  out  1  result of the last test, valid from the done pulse until the next done pulse
err_cnt  out  ERR_W  count of failed tests, saturating

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, bit counter=0, and all latched registers=0. Outputs reset to: scan_en=0, scan_in=0, op_code/A/B=0, busy=0, done=0, pass=0, err_cnt=0. A reset mid-test aborts immediately. No done pulse is produced and err_cnt is not touched.
- States: IDLE -> LOAD -> CAPTURE -> UNLOAD -> DONE -> IDLE.
- IDLE: when start=1 at a clock edge, latch pat_in, exp_in, op_in, a_in and b_in, clear the counter, and go to LOAD. While busy=1, start is ignored and latched values do not change.
- LOAD, CHAIN_LEN cycles: scan_en=1, and scan_in = pat[CHAIN_LEN-1-cnt] (MSB first, because the chain shifts toward the MSB). After the last LOAD edge the ALU register holds pat.
- CAPTURE, 1 cycle: scan_en=0 and the latched op/A/B are driven. The ALU register loads the functional result.
- UNLOAD, CHAIN_LEN cycles: scan_en=1 and scan_in=0. At each edge, cap <= {cap[CHAIN_LEN-2:0], chain_so}, which samples chain_so before the shift. After CHAIN_LEN edges, cap = the captured word.
- DONE, 1 cycle: done=1 and pass <= (cap == exp). If they mismatch, err_cnt increments, holding at all-ones.
- op_code/A/B carry the latched values in LOAD through DONE and are 0 in IDLE.
- Latency: with the start edge at t0, done is high in cycle t0+2*CHAIN_LEN+2. For CHAIN_LEN=4 that is t10. The earliest next start is accepted at t11.
- Counter: increments in LOAD/UNLOAD and clears on each state exit. Its terminal value is CHAIN_LEN-1.
- pass and err_cnt update only in DONE.

Optional Feature:
Macro ALU_SCAN_CTRL_FLUSH_EN.
- Defined: a FLUSH state of CHAIN_LEN cycles is inserted between LOAD and CAPTURE. During FLUSH, scan_en=1 and scan_in re-shifts pat MSB first, while chain_so is shifted into cap. At FLUSH exit, cap != pat sets a sticky flush_fail, which forces pass=0 in DONE (counted once in err_cnt). Latency becomes 3*CHAIN_LEN+2.
- Not defined: there is no FLUSH state and the latency is 2*CHAIN_LEN+2.

Test Plan:
- ADD, pat=1010, op=00, A=3, B=5, exp=1000 -> scan_in sequence 1,0,1,0 in LOAD; scan_en=0 only at t5; done at t10 with pass=1; err_cnt=0.
- SUB, op=01, A=2, B=5, exp=1101 -> pass=1. Then OR, op=11, A=9, B=6, exp=0000 (actual 1111) -> pass=0, err_cnt=1.
- start pulsed again at t3 with different operands -> ignored; the original test completes with the original results; busy stays high t1..t10.
- rst driven low during UNLOAD (t7) -> same-cycle outputs go to 0 and state to IDLE; no done pulse; a subsequent test completes normally.
- ERR_W=2 with 5 consecutive failing tests -> err_cnt goes 1,2,3,3,3.
- With FLUSH_EN defined, chain_so stuck at 0 and pat=1111 -> done at t14 with pass=0 even when exp matches; err_cnt increments once.
